uart_tx: RTL and testbench

- UART transmitter; the transmit-side counterpart of the team's UART receiver.
- Accepts bytes over a valid/ready handshake and serialises them LSB-first on tx_o: start bit, 8 data bits, optional parity, 1 or 2 stop bits.
- Honours the remote receiver's active-low clear-to-send (cts_i), so it pairs directly with the receiver's rts_o.
- Sits between a byte producer (CPU/FIFO) and the pad.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_tx_if.sv | 8 +
 rtl/uart_baud_gen.sv | 19 +
 rtl/uart_tx.sv | 77 +++++++
 tb/tb_uart_tx.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings, parity codes and baud divisor for the UART blocks
package uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  function automatic logic [31:0] baud_div(input logic [31:0] freq_mhz, input logic [31:0] baud);
    return (freq_mhz * 32'd1000000) / baud;
  endfunction
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte valid/ready handshake between a producer and the transmitter
interface uart_tx_if;
  logic [7:0] tx_data_i;
  logic       tx_vld_i;
  logic       tx_rdy_o;
  modport master (output tx_data_i, tx_vld_i, input tx_rdy_o);
  modport slave  (input tx_data_i, tx_vld_i, output tx_rdy_o);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter, tick on the last cycle of each bit, cleared while disabled
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int FREQUENCY = 130,
  parameter int BAUDRATE  = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam logic [31:0] N = baud_div(FREQUENCY, BAUDRATE);
  logic [31:0] count;
  assign tick = en & (count == N - 32'd1);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else     count <= (en & ~tick) ? count + 32'd1 : '0;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: serialises handshaked bytes LSB-first with optional parity, 1/2 stop bits and CTS gating
module uart_tx
  import uart_pkg::*;
#(
  parameter int FREQUENCY = 130,
  parameter int BAUDRATE  = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus,
  input  logic     cts_i,
  output logic     tx_o,
  output logic     tx_busy_o,
  output logic     tx_done_o
);
  localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;
  state_t     state, nxt;
  logic [1:0] cts_s;
  logic [7:0] sh, sh_nxt;
  logic [2:0] idx, idx_nxt;
  logic       par, tick, accept, data_end, stop_end, tx_nxt;

  uart_baud_gen #(.FREQUENCY(FREQUENCY), .BAUDRATE(BAUDRATE)) u_baud (
    .clk(clk), .rst(rst), .en(tx_busy_o), .tick(tick)
  );

  assign tx_busy_o    = state != ST_IDLE;
  assign bus.tx_rdy_o = (state == ST_IDLE) & ~cts_s[1];
  assign accept       = bus.tx_vld_i & bus.tx_rdy_o;
  assign data_end     = (state == ST_DATA) & tick & (idx == 3'd7);
  assign stop_end     = (state == ST_STOP) & tick & (idx == STOP_LAST);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   nxt = accept ? ST_START : ST_IDLE;
      ST_START:  nxt = tick ? ST_DATA : ST_START;
      ST_DATA:   nxt = data_end ? ((PARITY != PAR_NONE) ? ST_PARITY : ST_STOP) : ST_DATA;
      ST_PARITY: nxt = tick ? ST_STOP : ST_PARITY;
      ST_STOP:   nxt = stop_end ? ST_IDLE : ST_STOP;
      default:   nxt = ST_IDLE;
    endcase
  end

  // idx counts data bits, then is reused to count stop bits
  always_comb begin
    sh_nxt  = accept ? bus.tx_data_i : ((state == ST_DATA) & tick) ? {1'b0, sh[7:1]} : sh;
    idx_nxt = (data_end | stop_end) ? 3'd0 :
              (((state == ST_DATA) | (state == ST_STOP)) & tick) ? idx + 3'd1 : idx;
    tx_nxt  = (nxt == ST_START)  ? 1'b0 :
              (nxt == ST_DATA)   ? sh_nxt[0] :
              (nxt == ST_PARITY) ? par : 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cts_s     <= 2'b11;
      sh        <= '0;
      idx       <= '0;
      par       <= 1'b0;
      tx_o      <= 1'b1;
      tx_done_o <= 1'b0;
    end else begin
      cts_s     <= {cts_s[0], cts_i};
      sh        <= sh_nxt;
      idx       <= idx_nxt;
      par       <= accept ? ((PARITY == PAR_ODD) ? ~^bus.tx_data_i : ^bus.tx_data_i) : par;
      tx_o      <= tx_nxt;
      tx_done_o <= stop_end;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of four transmitter configurations at N = 10 cycles per bit
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cts = '0;
  logic [3:0] vld = '0;
  logic [3:0] tx, rdy, busy, done;
  logic [7:0] data [4];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // unit 0: no parity, 1 stop; 1: even; 2: odd; 3: no parity, 2 stop
  for (genvar g = 0; g < 4; g++) begin : gen_u
    uart_tx_if bus();
    assign bus.tx_data_i = data[g];
    assign bus.tx_vld_i  = vld[g];
    assign rdy[g]        = bus.tx_rdy_o;
    uart_tx #(
      .FREQUENCY(1), .BAUDRATE(100000),
      .PARITY(g == 1 ? 2 : g == 2 ? 1 : 0),
      .STOP_BITS(g == 3 ? 2 : 1)
    ) dut (
      .clk(clk), .rst(rst), .bus(bus), .cts_i(cts[g]),
      .tx_o(tx[g]), .tx_busy_o(busy[g]), .tx_done_o(done[g])
    );
  end

  task automatic run_frame(input int u, input logic [7:0] d, input bit chained, input bit hold,
                           input logic [7:0] nd, input bit scramble, input bit cts_mid);
    int par, sb, frame, w, last;
    logic [11:0] bits;
    logic exp_tx;
    par   = (u == 1) ? 2 : (u == 2) ? 1 : 0;
    sb    = (u == 3) ? 2 : 1;
    frame = (9 + ((par != 0) ? 1 : 0) + sb) * 10;
    last  = hold ? frame : frame + 2;
    bits  = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (par != 0) bits[9] = (par == 2) ? ^d : ~^d;
    if (!chained) begin
      @(negedge clk);
      data[u] = d;
      vld[u]  = 1'b1;
    end
    w = 0;
    while (rdy[u] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (rdy[u] !== 1'b1) begin
      miscompares++;
      $display("FAIL frame_rdy u%0d: rdy=%b required 1", u, rdy[u]);
      vld[u] = 1'b0;
      return;
    end
    @(posedge clk);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (hold) data[u] = nd;
        else      vld[u] = 1'b0;
      end
      if (scramble) data[u] = 8'($urandom);
      if (cts_mid && k == 35) cts[u] = 1'b1;
      exp_tx = (k < frame) ? bits[k/10] : 1'b1;
      vectors++;
      if (tx[u] !== exp_tx) begin
        miscompares++;
        $display("FAIL tx u%0d k=%0d: got %b need %b", u, k, tx[u], exp_tx);
      end
      vectors++;
      if (done[u] !== (k == frame)) begin
        miscompares++;
        $display("FAIL done u%0d k=%0d: got %b need %b", u, k, done[u], k == frame);
      end
      vectors++;
      if (busy[u] !== (k < frame)) begin
        miscompares++;
        $display("FAIL busy u%0d k=%0d: got %b need %b", u, k, busy[u], k < frame);
      end
    end
    if (hold) begin
      vectors++;
      if (rdy[u] !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_rdy u%0d: rdy=%b required 1 in done cycle", u, rdy[u]);
      end
    end
  endtask

  task automatic test_reset();
    foreach (data[i]) data[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 4; u++) begin
      vectors += 4;
      if (tx[u] !== 1'b1)   begin miscompares++; $display("FAIL reset_tx u%0d: got %b need 1", u, tx[u]); end
      if (rdy[u] !== 1'b0)  begin miscompares++; $display("FAIL reset_rdy u%0d: got %b need 0", u, rdy[u]); end
      if (busy[u] !== 1'b0) begin miscompares++; $display("FAIL reset_busy u%0d: got %b need 0", u, busy[u]); end
      if (done[u] !== 1'b0) begin miscompares++; $display("FAIL reset_done u%0d: got %b need 0", u, done[u]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    run_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_parity();
    run_frame(1, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    run_frame(2, 8'h07, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame(3, 8'h55, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    run_frame(3, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_cts();
    int n;
    @(negedge clk);
    cts[0] = 1'b1;
    repeat (3) @(negedge clk);
    data[0] = 8'h96;
    vld[0]  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors += 3;
      if (rdy[0] !== 1'b0)  begin miscompares++; $display("FAIL cts_rdy i=%0d: got %b need 0", i, rdy[0]); end
      if (tx[0] !== 1'b1)   begin miscompares++; $display("FAIL cts_tx i=%0d: got %b need 1", i, tx[0]); end
      if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL cts_busy i=%0d: got %b need 0", i, busy[0]); end
    end
    cts[0] = 1'b0;
    n = 0;
    while (rdy[0] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 2) begin miscompares++; $display("FAIL cts_latency: got %0d cycles need 2", n); end
    run_frame(0, 8'h96, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    vectors++;
    if (rdy[0] !== 1'b0) begin miscompares++; $display("FAIL cts_after: rdy=%b need 0", rdy[0]); end
    cts[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    int w;
    @(negedge clk);
    data[0] = 8'hFF;
    vld[0]  = 1'b1;
    w = 0;
    while (rdy[0] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (44) @(negedge clk);
    vectors++;
    if (busy[0] !== 1'b1) begin miscompares++; $display("FAIL rmid_busy_pre: got %b need 1", busy[0]); end
    #2 rst = 1'b1;
    #1;
    vectors += 4;
    if (tx[0] !== 1'b1)   begin miscompares++; $display("FAIL rmid_tx: got %b need 1", tx[0]); end
    if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b need 0", busy[0]); end
    if (rdy[0] !== 1'b0)  begin miscompares++; $display("FAIL rmid_rdy: got %b need 0", rdy[0]); end
    if (done[0] !== 1'b0) begin miscompares++; $display("FAIL rmid_done: got %b need 0", done[0]); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors += 2;
      if (done[0] !== 1'b0) begin miscompares++; $display("FAIL rpost_done i=%0d: got %b need 0", i, done[0]); end
      if (tx[0] !== 1'b1)   begin miscompares++; $display("FAIL rpost_tx i=%0d: got %b need 1", i, tx[0]); end
    end
    run_frame(0, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_data_change();
    run_frame(0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_cts();
    test_reset_mid();
    test_data_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
